// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM encoding,
// master identifiers and the legal read-latency range.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_e;

    localparam logic MST_CPU = 1'b0;
    localparam logic MST_DBG = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 7;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that did not win last time. Purely combinational so it can be
// reused in front of any registered resource sequencer.
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_owner_i,
    output logic grant_valid_o,
    output logic grant_id_o
);

    // Select the winner from the request pair and the previous owner
    always_comb begin
        grant_valid_o = 1'b0;
        grant_id_o    = 1'b0;
        case ({req1_i, req0_i})
            2'b01: begin
                grant_valid_o = 1'b1;
                grant_id_o    = 1'b0;
            end
            2'b10: begin
                grant_valid_o = 1'b1;
                grant_id_o    = 1'b1;
            end
            2'b11: begin
                grant_valid_o = 1'b1;
                grant_id_o    = ~last_owner_i;
            end
            default: begin
                grant_valid_o = 1'b0;
                grant_id_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter/sequencer for the single-ported unified memory.
// Master 0 is the CPU memory port, master 1 the loader/debug port. One
// transaction at a time: IDLE -> ISSUE -> (WAIT for reads) -> ACK -> IDLE.
// Read data is sampled at the end of the cycle RD_LAT cycles after ISSUE,
// and every output comes straight from a register.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    // WAIT runs RD_LAT cycles; the counter hits zero in the capture cycle
    localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

    arb_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_owner_q, last_owner_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        busy_q, busy_d;
    logic        grant_valid_s;
    logic        grant_id_s;

    rr_pick2 u_pick (
        .req0_i        (m0_req),
        .req1_i        (m1_req),
        .last_owner_i  (last_owner_q),
        .grant_valid_o (grant_valid_s),
        .grant_id_o    (grant_id_s)
    );

    // Next-state, transaction latch and registered-output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    owner_d      = grant_id_s;
                    last_owner_d = grant_id_s;
                    state_d      = ST_ISSUE;
                    if (grant_id_s == MST_DBG) begin
                        we_d    = m1_we;
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                        be_d    = m1_be;
                    end else begin
                        we_d    = m0_we;
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                        be_d    = m0_be;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_ACK;
                    if (owner_q == MST_DBG) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step
        mem_en_d = (state_d == ST_ISSUE);
        mem_we_d = (state_d == ST_ISSUE) && we_d;
        ack0_d   = (state_d == ST_ACK) && (owner_d == MST_CPU);
        ack1_d   = (state_d == ST_ACK) && (owner_d == MST_DBG);
        busy_d   = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
        end
    end

    assign m0_ack    = ack0_q;
    assign m1_ack    = ack1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances with RD_LAT = 1, 2, 4, 7 share all
// inputs; single-master transactions come from a vector table, multi-cycle
// corner cases (tie, alternation, async reset) are hand-written sequences.
module tb_mem_arbiter;

    localparam int NL = 4;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] mem_rdata;
    logic        cnt_mode;
    logic [31:0] mem_const;
    int          gcyc;

    logic        m0_ack_s   [NL];
    logic        m1_ack_s   [NL];
    logic [31:0] m0_rdata_s [NL];
    logic [31:0] m1_rdata_s [NL];
    logic        mem_en_s   [NL];
    logic        mem_we_s   [NL];
    logic [31:0] mem_addr_s [NL];
    logic [31:0] mem_wdata_s[NL];
    logic [3:0]  mem_be_s   [NL];
    logic        busy_s     [NL];
    logic        owner_s    [NL];

    for (genvar g = 0; g < NL; g++) begin : g_dut
        mem_arbiter #(.RD_LAT((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 7)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .m0_req    (m0_req),
            .m0_we     (m0_we),
            .m0_addr   (m0_addr),
            .m0_wdata  (m0_wdata),
            .m0_be     (m0_be),
            .m1_req    (m1_req),
            .m1_we     (m1_we),
            .m1_addr   (m1_addr),
            .m1_wdata  (m1_wdata),
            .m1_be     (m1_be),
            .m0_ack    (m0_ack_s[g]),
            .m0_rdata  (m0_rdata_s[g]),
            .m1_ack    (m1_ack_s[g]),
            .m1_rdata  (m1_rdata_s[g]),
            .mem_en    (mem_en_s[g]),
            .mem_we    (mem_we_s[g]),
            .mem_addr  (mem_addr_s[g]),
            .mem_wdata (mem_wdata_s[g]),
            .mem_be    (mem_be_s[g]),
            .mem_rdata (mem_rdata),
            .busy      (busy_s[g]),
            .owner     (owner_s[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: counter mode changes the data every cycle
    always @(posedge clk) begin
        #1;
        gcyc <= gcyc + 1;
    end
    assign mem_rdata = cnt_mode ? {16'hDA7A, gcyc[15:0]} : mem_const;

    int checks = 0;
    int errors = 0;
    int cyc;

    int          a0_n[NL], a1_n[NL], a0_c[NL], a1_c[NL], en_n[NL], en_c[NL], seqn[NL];
    logic        we_at_en[NL];
    logic [31:0] addr_at_en[NL], wdata_at_en[NL];
    logic [3:0]  be_at_en[NL];
    logic        own_hist[NL][32];
    logic        busy_hist[NL][32];
    logic        seq[NL][16];
    logic [31:0] rdm0[NL], rdm1[NL];

    typedef struct {
        logic        mst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        cmode;
        logic [31:0] rdconst;
        logic        exp_owner;
    } vec_t;

    vec_t vecs[6];

    function automatic int lat_of(input int l);
        case (l)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 7;
        endcase
    endfunction

    task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane %0d (RD_LAT=%0d): got 0x%08h expected 0x%08h", nm, l, lat_of(l), act, exp);
        end
    endtask

    task automatic mon_clear();
        cyc = 0;
        for (int l = 0; l < NL; l++) begin
            a0_n[l] = 0; a1_n[l] = 0; a0_c[l] = -1; a1_c[l] = -1;
            en_n[l] = 0; en_c[l] = -1; seqn[l] = 0;
        end
    endtask

    // Sample every lane mid-cycle, then advance to 2 time units past the edge
    task automatic tick();
        @(negedge clk);
        for (int l = 0; l < NL; l++) begin
            if (cyc < 32) begin
                own_hist[l][cyc]  = owner_s[l];
                busy_hist[l][cyc] = busy_s[l];
            end
            if (m0_ack_s[l]) begin
                a0_n[l]++;
                if (a0_n[l] == 1) a0_c[l] = cyc;
            end
            if (m1_ack_s[l]) begin
                a1_n[l]++;
                if (a1_n[l] == 1) a1_c[l] = cyc;
            end
            if ((m0_ack_s[l] || m1_ack_s[l]) && seqn[l] < 16) begin
                seq[l][seqn[l]] = m1_ack_s[l];
                seqn[l]++;
            end
            if (mem_en_s[l]) begin
                en_n[l]++;
                if (en_n[l] == 1) begin
                    en_c[l]        = cyc;
                    we_at_en[l]    = mem_we_s[l];
                    addr_at_en[l]  = mem_addr_s[l];
                    wdata_at_en[l] = mem_wdata_s[l];
                    be_at_en[l]    = mem_be_s[l];
                end
            end
        end
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic chk_zero(input string nm);
        for (int l = 0; l < NL; l++) begin
            chk({nm, "_ctl"}, l, {26'd0, m0_ack_s[l], m1_ack_s[l], mem_en_s[l], mem_we_s[l], busy_s[l], owner_s[l]}, 32'd0);
            chk({nm, "_addr"}, l, mem_addr_s[l], 32'd0);
            chk({nm, "_wdata"}, l, mem_wdata_s[l], 32'd0);
            chk({nm, "_be"}, l, 32'(mem_be_s[l]), 32'd0);
            chk({nm, "_rd0"}, l, m0_rdata_s[l], 32'd0);
            chk({nm, "_rd1"}, l, m1_rdata_s[l], 32'd0);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        reset = 1'b1;
        for (int l = 0; l < NL; l++) begin
            rdm0[l] = 32'd0;
            rdm1[l] = 32'd0;
        end
    endtask

    task automatic drive(input vec_t v);
        if (v.mst) begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata; m1_be = v.be;
        end else begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata; m0_be = v.be;
        end
    endtask

    // One transaction: request held in cycle 0 only, dropped during ISSUE
    task automatic run_vec(input vec_t v);
        int t0;
        int lat;
        int exp_ack;
        logic [31:0] exp_rd;
        mon_clear();
        t0        = gcyc;
        cnt_mode  = v.cmode;
        mem_const = v.rdconst;
        drive(v);
        tick();
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (13) tick();
        for (int l = 0; l < NL; l++) begin
            lat     = lat_of(l);
            exp_ack = v.we ? 2 : lat + 2;
            exp_rd  = v.cmode ? {16'hDA7A, 16'(t0 + 1 + lat)} : v.rdconst;
            if (!v.we) begin
                if (v.mst) rdm1[l] = exp_rd;
                else       rdm0[l] = exp_rd;
            end
            chk("ack_count_owner", l, v.mst ? a1_n[l] : a0_n[l], 32'd1);
            chk("ack_count_other", l, v.mst ? a0_n[l] : a1_n[l], 32'd0);
            chk("ack_cycle", l, v.mst ? a1_c[l] : a0_c[l], exp_ack);
            chk("mem_en_count", l, en_n[l], 32'd1);
            chk("mem_en_cycle", l, en_c[l], 32'd1);
            chk("mem_we", l, 32'(we_at_en[l]), 32'(v.we));
            chk("mem_addr", l, addr_at_en[l], v.addr);
            if (v.we) begin
                chk("mem_wdata", l, wdata_at_en[l], v.wdata);
                chk("mem_be", l, 32'(be_at_en[l]), 32'(v.be));
            end
            chk("busy_issue", l, 32'(busy_hist[l][1]), 32'd1);
            chk("busy_end", l, 32'(busy_s[l]), 32'd0);
            chk("owner", l, 32'(owner_s[l]), 32'(v.exp_owner));
            chk("m0_rdata", l, m0_rdata_s[l], rdm0[l]);
            chk("m1_rdata", l, m1_rdata_s[l], rdm1[l]);
        end
    endtask

    initial begin
        int t0;
        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_be = 4'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_be = 4'd0;
        cnt_mode = 1'b0;
        mem_const = 32'd0;
        gcyc = 0;
        cyc = 0;

        vecs[0] = '{mst: 1'b0, we: 1'b0, addr: 32'h0000_0040, wdata: 32'h0, be: 4'h0, cmode: 1'b0, rdconst: 32'hDEAD_BEEF, exp_owner: 1'b0};
        vecs[1] = '{mst: 1'b1, we: 1'b0, addr: 32'h0000_0100, wdata: 32'h0, be: 4'h0, cmode: 1'b1, rdconst: 32'h0, exp_owner: 1'b1};
        vecs[2] = '{mst: 1'b0, we: 1'b1, addr: 32'h0000_0010, wdata: 32'h1234_5678, be: 4'hF, cmode: 1'b0, rdconst: 32'h5555_5555, exp_owner: 1'b0};
        vecs[3] = '{mst: 1'b1, we: 1'b1, addr: 32'h0000_2004, wdata: 32'hCAFE_F00D, be: 4'h0, cmode: 1'b0, rdconst: 32'hAAAA_AAAA, exp_owner: 1'b1};
        vecs[4] = '{mst: 1'b0, we: 1'b0, addr: 32'h0000_0080, wdata: 32'h0, be: 4'h0, cmode: 1'b1, rdconst: 32'h0, exp_owner: 1'b0};
        vecs[5] = '{mst: 1'b1, we: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h0, be: 4'h0, cmode: 1'b0, rdconst: 32'h0BAD_F00D, exp_owner: 1'b1};

        #1;
        @(posedge clk);
        #2;
        apply_reset();
        tick();

        // Single-master transactions from the table
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Simultaneous requests right after reset: M0 write first, then M1 read
        apply_reset();
        mon_clear();
        cnt_mode = 1'b1;
        t0 = gcyc;
        m0_we = 1'b1; m0_addr = 32'h0000_0010; m0_wdata = 32'h1234_5678; m0_be = 4'hF;
        m1_we = 1'b0; m1_addr = 32'h0000_0020;
        m0_req = 1'b1;
        m1_req = 1'b1;
        tick();
        m0_req = 1'b0;
        repeat (3) tick();
        m1_req = 1'b0;
        repeat (14) tick();
        for (int l = 0; l < NL; l++) begin
            chk("tie_m0_ack_cycle", l, a0_c[l], 32'd2);
            chk("tie_m0_ack_count", l, a0_n[l], 32'd1);
            chk("tie_m1_ack_cycle", l, a1_c[l], 5 + lat_of(l));
            chk("tie_m1_ack_count", l, a1_n[l], 32'd1);
            chk("tie_owner_c1", l, 32'(own_hist[l][1]), 32'd0);
            chk("tie_owner_c4", l, 32'(own_hist[l][4]), 32'd1);
            chk("tie_m1_rdata", l, m1_rdata_s[l], {16'hDA7A, 16'(t0 + 4 + lat_of(l))});
        end

        // Both masters request continuously: grants must alternate
        apply_reset();
        mon_clear();
        m0_we = 1'b1; m0_addr = 32'h0000_0100; m0_wdata = 32'hA0A0_A0A0; m0_be = 4'h3;
        m1_we = 1'b1; m1_addr = 32'h0000_0200; m1_wdata = 32'hB1B1_B1B1; m1_be = 4'hC;
        m0_req = 1'b1;
        m1_req = 1'b1;
        repeat (24) tick();
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (3) tick();
        for (int l = 0; l < NL; l++) begin
            chk("alt_ack_total", l, seqn[l], 32'd8);
            chk("alt_m0_acks", l, a0_n[l], 32'd4);
            chk("alt_m1_acks", l, a1_n[l], 32'd4);
            for (int k = 0; k < 8; k++) begin
                chk("alt_order", l, 32'(seq[l][k]), 32'(k % 2));
            end
        end

        // Asynchronous reset during the second WAIT cycle of the RD_LAT=4 lane
        apply_reset();
        mon_clear();
        cnt_mode = 1'b1;
        m0_we = 1'b0; m0_addr = 32'h0000_0040;
        m0_req = 1'b1;
        tick();
        m0_req = 1'b0;
        tick();
        tick();
        chk("pre_reset_busy", 2, 32'(busy_s[2]), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk_zero("async_reset");
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int l = 0; l < NL; l++) begin
            rdm0[l] = 32'd0;
            rdm1[l] = 32'd0;
        end
        mon_clear();
        repeat (12) tick();
        for (int l = 0; l < NL; l++) begin
            chk("post_reset_acks", l, a0_n[l] + a1_n[l], 32'd0);
            chk("post_reset_en", l, en_n[l], 32'd0);
            chk("post_reset_busy", l, 32'(busy_s[l]), 32'd0);
        end
        run_vec(vecs[4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
